// File: rtl/eth_arp_rx.sv
// rtl/eth_arp_rx.sv - byte-serial Ethernet ARP receiver with CRC-32 check and address filtering
// Emits captured sender fields on accept, or a drop pulse for any rejected frame.
module eth_arp_rx #(
  parameter int MIN_FRAME_LEN = 64,
  parameter bit CHECK_FCS     = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  input  logic [47:0] mac_local,
  input  logic [31:0] ip_local,
  output logic        arp_valid,
  output logic        arp_oper,
  output logic [47:0] mac_s_addr,
  output logic [31:0] ip_s_addr,
  output logic        frame_drop
);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_ARP, S_TAIL, S_DROP} state_t;

  state_t      r_state, w_next;
  logic        r_dv_prev;
  logic [10:0] r_count;
  logic [31:0] r_crc, w_crc_next;
  logic        r_reject, r_ne_local, r_ne_bcast;
  logic [47:0] r_sh_mac;
  logic [31:0] r_sh_ip;
  logic        r_sh_oper;
  logic        w_in_frame, w_frame_end, w_fcs_ok, w_accept, w_drop;
  logic        w_byte_bad, w_sfd;
  logic [7:0]  w_local_byte;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // IDLE only starts on a rising edge of data_valid, so a frame cut by reset is skipped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (data_valid && !r_dv_prev) w_next = (data_in == 8'h55) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE: begin
        if (!data_valid)            w_next = S_IDLE;
        else if (data_in == 8'hD5)  w_next = S_HEADER;
        else if (data_in != 8'h55)  w_next = S_DROP;
      end
      S_HEADER:   begin
        if (!data_valid)              w_next = S_IDLE;
        else if (r_count == 11'd13)   w_next = S_ARP;
      end
      S_ARP:      begin
        if (!data_valid)              w_next = S_IDLE;
        else if (r_count == 11'd41)   w_next = S_TAIL;
      end
      S_TAIL:     if (!data_valid) w_next = S_IDLE;
      S_DROP:     if (!data_valid) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sfd       = (r_state == S_PREAMBLE) && data_valid && (data_in == 8'hD5);
    w_in_frame  = r_state inside {S_HEADER, S_ARP, S_TAIL};
    w_frame_end = w_in_frame && !data_valid;
    w_fcs_ok    = !CHECK_FCS || (r_crc == 32'hDEBB20E3);
    w_accept    = w_frame_end && (r_state == S_TAIL) && !r_reject && !(r_ne_local && r_ne_bcast)
                  && (r_count >= 11'(MIN_FRAME_LEN)) && w_fcs_ok;
    w_drop      = (w_frame_end && !w_accept) || ((r_state == S_DROP) && !data_valid);
  end

  // Fixed-value fields indexed by post-SFD byte position (header at 0, ARP at 14).
  always_comb begin
    w_byte_bad   = 1'b0;
    w_local_byte = 8'h00;
    case (r_count)
      11'd0:  w_local_byte = mac_local[47:40];
      11'd1:  w_local_byte = mac_local[39:32];
      11'd2:  w_local_byte = mac_local[31:24];
      11'd3:  w_local_byte = mac_local[23:16];
      11'd4:  w_local_byte = mac_local[15:8];
      11'd5:  w_local_byte = mac_local[7:0];
      11'd12: w_byte_bad = (data_in != 8'h08);
      11'd13: w_byte_bad = (data_in != 8'h06);
      11'd14: w_byte_bad = (data_in != 8'h00);
      11'd15: w_byte_bad = (data_in != 8'h01);
      11'd16: w_byte_bad = (data_in != 8'h08);
      11'd17: w_byte_bad = (data_in != 8'h00);
      11'd18: w_byte_bad = (data_in != 8'h06);
      11'd19: w_byte_bad = (data_in != 8'h04);
      11'd20: w_byte_bad = (data_in != 8'h00);
      11'd21: w_byte_bad = !((data_in == 8'h01) || (data_in == 8'h02));
      11'd38: w_byte_bad = (data_in != ip_local[31:24]);
      11'd39: w_byte_bad = (data_in != ip_local[23:16]);
      11'd40: w_byte_bad = (data_in != ip_local[15:8]);
      11'd41: w_byte_bad = (data_in != ip_local[7:0]);
      default: w_byte_bad = 1'b0;
    endcase
  end

  always_comb begin
    w_crc_next = r_crc;
    for (int i = 0; i < 8; i++) begin
      if (w_crc_next[0] ^ data_in[i]) w_crc_next = (w_crc_next >> 1) ^ 32'hEDB88320;
      else                            w_crc_next = w_crc_next >> 1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_dv_prev  <= 1'b1;
      r_count    <= 11'd0;
      r_crc      <= 32'hFFFFFFFF;
      r_reject   <= 1'b0;
      r_ne_local <= 1'b0;
      r_ne_bcast <= 1'b0;
      r_sh_mac   <= 48'd0;
      r_sh_ip    <= 32'd0;
      r_sh_oper  <= 1'b0;
      arp_valid  <= 1'b0;
      frame_drop <= 1'b0;
      arp_oper   <= 1'b0;
      mac_s_addr <= 48'd0;
      ip_s_addr  <= 32'd0;
    end else begin
      r_dv_prev  <= data_valid;
      arp_valid  <= w_accept;
      frame_drop <= w_drop;
      if (w_accept) begin
        arp_oper   <= r_sh_oper;
        mac_s_addr <= r_sh_mac;
        ip_s_addr  <= r_sh_ip;
      end
      if (w_sfd) begin
        r_count    <= 11'd0;
        r_crc      <= 32'hFFFFFFFF;
        r_reject   <= 1'b0;
        r_ne_local <= 1'b0;
        r_ne_bcast <= 1'b0;
      end else if (w_in_frame && data_valid) begin
        r_crc <= w_crc_next;
        if (r_count != 11'h7FF) r_count <= r_count + 11'd1;
        if ((r_state != S_TAIL) && w_byte_bad) r_reject <= 1'b1;
        if ((r_state == S_HEADER) && (r_count < 11'd6)) begin
          if (data_in != w_local_byte) r_ne_local <= 1'b1;
          if (data_in != 8'hFF)        r_ne_bcast <= 1'b1;
        end
        if (r_count == 11'd21) r_sh_oper <= data_in[1];
        if ((r_count >= 11'd22) && (r_count <= 11'd27)) r_sh_mac <= {r_sh_mac[39:0], data_in};
        if ((r_count >= 11'd28) && (r_count <= 11'd31)) r_sh_ip  <= {r_sh_ip[23:0], data_in};
      end
    end
  end

endmodule

// File: tb/tb_eth_arp_rx.sv
// tb/tb_eth_arp_rx.sv - scoreboard bench for eth_arp_rx
// Two instances (FCS checked / ignored) share stimulus; each has its own expected queue.
module tb_eth_arp_rx;
  localparam logic [47:0] MAC_L = 48'h020000000010;
  localparam logic [31:0] IP_L  = 32'hC0A80101;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

  logic        aclk = 1'b0, areset = 1'b1, data_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [47:0] mac_local = MAC_L;
  logic [31:0] ip_local = IP_L;
  logic        a_valid, a_oper, a_drop, b_valid, b_oper, b_drop;
  logic [47:0] a_mac, b_mac;
  logic [31:0] a_ip, b_ip;

  eth_arp_rx #(.MIN_FRAME_LEN(64), .CHECK_FCS(1'b1)) dut (
    .aclk(aclk), .areset(areset), .data_valid(data_valid), .data_in(data_in),
    .mac_local(mac_local), .ip_local(ip_local), .arp_valid(a_valid), .arp_oper(a_oper),
    .mac_s_addr(a_mac), .ip_s_addr(a_ip), .frame_drop(a_drop));

  eth_arp_rx #(.MIN_FRAME_LEN(64), .CHECK_FCS(1'b0)) dut_nofcs (
    .aclk(aclk), .areset(areset), .data_valid(data_valid), .data_in(data_in),
    .mac_local(mac_local), .ip_local(ip_local), .arp_valid(b_valid), .arp_oper(b_oper),
    .mac_s_addr(b_mac), .ip_s_addr(b_ip), .frame_drop(b_drop));

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic        drop;
    logic        oper;
    logic [47:0] mac;
    logic [31:0] ip;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, fall_cyc = -10;
  logic        prev_dv = 1'b0;
  logic        h_oper[2];
  logic [47:0] h_mac[2];
  logic [31:0] h_ip[2];
  logic [7:0]  body[$], tx[$];

  always @(posedge aclk) begin
    cyc = cyc + 1;
    if (!data_valid && prev_dv) fall_cyc = cyc;
    prev_dv = data_valid;
  end

  task automatic check_out(input int id, input logic v, input logic d, input logic o,
                           input logic [47:0] m, input logic [31:0] ip);
    exp_t e;
    if (v && d) begin
      n_cmp++; n_bad++;
      $display("FAIL both_pulses inst%0d: arp_valid=1 frame_drop=1, required exclusive", id);
    end else if (v || d) begin
      n_cmp++;
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        n_bad++;
        $display("FAIL unexpected_pulse inst%0d: valid=%0b drop=%0b, required none", id, v, d);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        if (d != e.drop || o != e.oper || m != e.mac || ip != e.ip) begin
          n_bad++;
          $display("FAIL result inst%0d: drop=%0b oper=%0b mac=%h ip=%h, required drop=%0b oper=%0b mac=%h ip=%h",
                   id, d, o, m, ip, e.drop, e.oper, e.mac, e.ip);
        end
        n_cmp++;
        if (cyc != fall_cyc) begin
          n_bad++;
          $display("FAIL latency inst%0d: pulse at edge %0d, required edge %0d", id, cyc, fall_cyc);
        end
      end
    end
  endtask

  always @(negedge aclk) begin
    check_out(0, a_valid, a_drop, a_oper, a_mac, a_ip);
    check_out(1, b_valid, b_drop, b_oper, b_mac, b_ip);
  end

  task automatic expect_res(input int id, input logic acc, input logic o,
                            input logic [47:0] m, input logic [31:0] ip);
    exp_t e;
    if (acc) begin h_oper[id] = o; h_mac[id] = m; h_ip[id] = ip; end
    e.drop = !acc; e.oper = h_oper[id]; e.mac = h_mac[id]; e.ip = h_ip[id];
    if (id == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic expect_both(input logic acc, input logic o, input logic [47:0] m, input logic [31:0] ip);
    expect_res(0, acc, o, m, ip);
    expect_res(1, acc, o, m, ip);
  endtask

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin h_oper[k] = 1'b0; h_mac[k] = 48'd0; h_ip[k] = 32'd0; end
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({a_valid, a_drop, a_oper, a_mac, a_ip} != 83'd0 || {b_valid, b_drop, b_oper, b_mac, b_ip} != 83'd0) begin
      n_bad++;
      $display("FAIL %s: outputs a=%h b=%h, required all zero", tag,
               {a_valid, a_drop, a_oper, a_mac, a_ip}, {b_valid, b_drop, b_oper, b_mac, b_ip});
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] op,
                       input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa,
                       input int npad, input int flip);
    logic [31:0] c;
    logic [47:0] src;
    src = 48'h0200000000AA;
    body.delete(); tx.delete();
    for (int i = 5; i >= 0; i--) body.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(src[8*i +: 8]);
    body.push_back(et[15:8]); body.push_back(et[7:0]);
    body.push_back(8'h00); body.push_back(8'h01); body.push_back(8'h08); body.push_back(8'h00);
    body.push_back(8'h06); body.push_back(8'h04); body.push_back(op[15:8]); body.push_back(op[7:0]);
    for (int i = 5; i >= 0; i--) body.push_back(sha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) body.push_back(spa[8*i +: 8]);
    repeat (6) body.push_back(8'h00);
    for (int i = 3; i >= 0; i--) body.push_back(tpa[8*i +: 8]);
    repeat (npad) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      c = c ^ {24'h0, body[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) body.push_back(c[8*i +: 8]);
    if (flip >= 0) body[flip] = body[flip] ^ 8'h01;
    repeat (7) tx.push_back(8'h55);
    tx.push_back(8'hD5);
    foreach (body[i]) tx.push_back(body[i]);
  endtask

  task automatic drive(input int n, input int gap, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk); #1;
      if (i == rst_at + 2) areset = 1'b0;
      data_valid = 1'b1; data_in = tx[i];
      if (i == rst_at) begin
        areset = 1'b1; reset_model();
        #1 check_zero("midframe_reset");
      end
    end
    repeat (gap) begin @(posedge aclk); #1; data_valid = 1'b0; data_in = 8'h00; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    repeat (3) @(posedge aclk);
    #1 check_zero("reset_state");
    @(posedge aclk); #1 areset = 1'b0;
    repeat (3) @(posedge aclk);

    // broadcast request
    build(BCAST, 16'h0806, 16'h0001, 48'h020000000001, 32'hC0A80102, IP_L, 18, -1);
    expect_both(1'b1, 1'b0, 48'h020000000001, 32'hC0A80102);
    drive(tx.size(), 4, -10);
    // unicast reply
    build(MAC_L, 16'h0806, 16'h0002, 48'h020000000002, 32'hC0A80103, IP_L, 18, -1);
    expect_both(1'b1, 1'b1, 48'h020000000002, 32'hC0A80103);
    drive(tx.size(), 4, -10);
    // SPA last byte bit flipped after FCS
    build(MAC_L, 16'h0806, 16'h0002, 48'h020000000003, 32'hC0A80104, IP_L, 18, 31);
    expect_res(0, 1'b0, 1'b0, 48'd0, 32'd0);
    expect_res(1, 1'b1, 1'b1, 48'h020000000003, 32'hC0A80105);
    drive(tx.size(), 4, -10);
    // field rejects
    build(BCAST, 16'h0806, 16'h0001, 48'h020000000001, 32'hC0A80102, 32'hC0A80199, 18, -1);
    expect_both(1'b0, 1'b0, 48'd0, 32'd0);
    drive(tx.size(), 4, -10);
    build(BCAST, 16'h0800, 16'h0001, 48'h020000000001, 32'hC0A80102, IP_L, 18, -1);
    expect_both(1'b0, 1'b0, 48'd0, 32'd0);
    drive(tx.size(), 4, -10);
    build(48'h020000000099, 16'h0806, 16'h0001, 48'h020000000001, 32'hC0A80102, IP_L, 18, -1);
    expect_both(1'b0, 1'b0, 48'd0, 32'd0);
    drive(tx.size(), 4, -10);
    // 63-byte frame, one short of minimum
    build(BCAST, 16'h0806, 16'h0001, 48'h020000000001, 32'hC0A80102, IP_L, 17, -1);
    expect_both(1'b0, 1'b0, 48'd0, 32'd0);
    drive(tx.size(), 4, -10);
    // truncated after 30 post-SFD bytes
    build(BCAST, 16'h0806, 16'h0001, 48'h020000000001, 32'hC0A80102, IP_L, 18, -1);
    expect_both(1'b0, 1'b0, 48'd0, 32'd0);
    drive(8 + 30, 4, -10);
    // corrupted preamble
    tx[3] = 8'h5A;
    expect_both(1'b0, 1'b0, 48'd0, 32'd0);
    drive(tx.size(), 4, -10);
    // short preamble only, silent
    tx.delete();
    repeat (5) tx.push_back(8'h55);
    drive(5, 4, -10);
    // reset in the middle of the ARP payload, silent
    build(BCAST, 16'h0806, 16'h0001, 48'h020000000004, 32'hC0A80106, IP_L, 18, -1);
    drive(tx.size(), 4, 8 + 20);
    build(MAC_L, 16'h0806, 16'h0002, 48'h020000000005, 32'hC0A80107, IP_L, 18, -1);
    expect_both(1'b1, 1'b1, 48'h020000000005, 32'hC0A80107);
    drive(tx.size(), 4, -10);
    // back-to-back with a single idle cycle
    expect_both(1'b1, 1'b0, 48'h020000000006, 32'hC0A80108);
    expect_both(1'b1, 1'b1, 48'h020000000007, 32'hC0A80109);
    build(BCAST, 16'h0806, 16'h0001, 48'h020000000006, 32'hC0A80108, IP_L, 18, -1);
    drive(tx.size(), 1, -10);
    build(MAC_L, 16'h0806, 16'h0002, 48'h020000000007, 32'hC0A80109, IP_L, 18, -1);
    drive(tx.size(), 10, -10);

    n_cmp++;
    if (q0.size() != 0) begin
      n_bad++;
      $display("FAIL pending_inst0: %0d results outstanding, required 0", q0.size());
    end
    n_cmp++;
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL pending_inst1: %0d results outstanding, required 0", q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eth_arp_rx.md
Name: eth_arp_rx

Overview:
- Receive-side counterpart to the ARP frame transmitter. Consumes the raw byte stream from the PHY/MAC interface (preamble through FCS) and runs a byte-serial parser through preamble/SFD, Ethernet header, ARP payload, padding and FCS.
- Checks CRC-32 and applies address and type filters.
- For each accepted ARP frame addressed to this node, presents the sender MAC, sender IP and opcode for the ARP responder/cache logic.

Parameters:
- MIN_FRAME_LEN, 64, minimum byte count from destination MAC through FCS inclusive; shorter frames are dropped.
- CHECK_FCS, 1, 1 = drop frames with a bad CRC; 0 = ignore the CRC result.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- data_valid  in  1  byte strobe; high for every byte of a frame, low between frames.
- data_in  in  8  received byte, first byte = first preamble byte.
- mac_local  in  48  this node's MAC address.
- ip_local  in  32  this node's IP address.
- arp_valid  out  1  one-cycle pulse: accepted ARP frame; fields below are valid.
- arp_oper  out  1  0 = request (OPER 0x0001), 1 = reply (OPER 0x0002).
- mac_s_addr  out  48  sender hardware address (SHA).
- ip_s_addr  out  32  sender protocol address (SPA).
- frame_drop  out  1  one-cycle pulse: frame ended and was rejected.

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, CRC register 0xFFFFFFFF. areset asserted mid-frame aborts parsing with no pulse. After release, parsing resumes only at the next rising edge of data_valid; bytes of the interrupted frame are ignored.
- States: IDLE, PREAMBLE, HEADER, ARP, TAIL, DROP.
- IDLE:
  - data_valid && data_in == 0x55 -> PREAMBLE.
  - data_valid with any other byte -> DROP.
- PREAMBLE:
  - 0x55 -> stay.
  - 0xD5 -> HEADER; byte counter cleared; CRC reset to 0xFFFFFFFF.
  - Any other byte -> DROP.
- HEADER (14 bytes):
  - Bytes 0-5 are the destination MAC. Pass if it equals mac_local or FF:FF:FF:FF:FF:FF.
  - Bytes 6-11 are the source MAC and are not checked.
  - Bytes 12-13 must be 0x08,0x06.
  - After byte 13 -> ARP.
- ARP (28 bytes, offsets relative to ARP start):
  - HTYPE 0x0001; PTYPE 0x0800; HLEN 0x06; PLEN 0x04.
  - OPER must be 0x0001 or 0x0002.
  - SHA at offsets 8-13 and SPA at 14-17 are captured into shadow registers.
  - THA is ignored.
  - TPA at 24-27 must equal ip_local.
  - After byte 27 -> TAIL.
- Filter flag: any field mismatch sets a sticky reject flag. Parsing continues so the CRC and length stay correct.
- TAIL: absorbs padding and FCS bytes; all go into the CRC.
- CRC-32 computation:
  - Reflected polynomial 0xEDB88320, processed LSB first, one byte per cycle.
  - Input covers every byte after the SFD, FCS included.
  - Good frame: register == 0xDEBB20E3 after the last byte.
- Frame end: the cycle in which data_valid is sampled low while in HEADER/ARP/TAIL.
  - Accept if: state was TAIL; reject flag clear; total post-SFD bytes >= MIN_FRAME_LEN; CRC good (when CHECK_FCS=1).
  - On accept: copy the shadow registers to mac_s_addr/ip_s_addr/arp_oper and pulse arp_valid in the next cycle.
  - Otherwise pulse frame_drop in the next cycle.
  - Return to IDLE.
- Byte counter: 11 bits, saturates at 2047; no wrap.
- DROP: waits for data_valid low, then pulses frame_drop once and returns to IDLE.
- data_valid low in IDLE or PREAMBLE: return to IDLE silently, with no pulse.
- Output hold: mac_s_addr, ip_s_addr and arp_oper hold their values until the next accept. arp_valid and frame_drop are never high in the same cycle.
- Back-to-back frames: a single low cycle between frames must be supported. The end-of-frame pulse and the IDLE check of the next byte occur without loss.
- Latency: arp_valid or frame_drop is asserted exactly 1 cycle after the first data_valid-low sample.

Test Plan:
- Broadcast ARP request:
  - Stimulus: 7x0x55, 0xD5; dst FF..FF; ethertype 0806; OPER 0001; SHA 02:00:00:00:00:01; SPA C0A80102; TPA = ip_local C0A80101; 18 pad bytes 0x00; correct FCS.
  - Required: arp_valid pulse 1 cycle after data_valid falls; arp_oper=0; mac_s_addr=0x020000000001; ip_s_addr=0xC0A80102.
- Unicast ARP reply to mac_local with OPER 0002 -> arp_valid, arp_oper=1.
- Same frame with one payload bit flipped -> frame_drop, no arp_valid, previous outputs unchanged. With CHECK_FCS=0 -> arp_valid.
- Field rejects -> frame_drop each, outputs unchanged:
  - TPA=C0A80199.
  - Ethertype 0800.
  - dst MAC 02:00:00:00:00:99.
- Truncation and framing errors:
  - data_valid drops after 30 post-SFD bytes -> frame_drop.
  - Preamble containing 0x5A -> frame_drop after data_valid low.
  - Only 5 bytes of 0x55, then data_valid low -> no pulse.
- Reset and back-to-back:
  - areset pulsed mid-ARP -> no pulse; the next valid frame is accepted.
  - Two good frames separated by one idle cycle -> two arp_valid pulses with the correct second-frame fields.
